// File: rtl/dual_btn_pulse.sv
// ---------------------------------------------------------------------------
// dual_btn_pulse
//
// Two-channel push-button conditioner. Each raw button input is brought into
// the clk domain by a two-flop synchroniser, debounced by a four-state FSM
// with a stability counter, and turned into a single-cycle press pulse. The
// debounced level of each channel is exported as well.
//
// The two channels are identical and independent. Channel 0 is X and
// channel 1 is Y.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable synchronised cycles needed to accept
//                     a level change. Must be at least 1.
//   CNT_W           : debounce counter width. It must satisfy
//                     2**CNT_W > DEBOUNCE_CYCLES-1.
//
// Ports
//   clk     in  : system clock; all logic runs on the rising edge
//   rst     in  : synchronous, active-high reset
//   btn_x   in  : raw button X, asynchronous to clk, may bounce
//   btn_y   in  : raw button Y, asynchronous to clk, may bounce
//   x       out : one-cycle pulse per accepted press of X
//   y       out : one-cycle pulse per accepted press of Y
//   x_level out : debounced level of X
//   y_level out : debounced level of Y
// ---------------------------------------------------------------------------
module dual_btn_pulse #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_x,
    input  logic btn_y,
    output logic x,
    output logic y,
    output logic x_level,
    output logic y_level
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    // Terminal count. The FSM leaves the WAIT state on this value, so the
    // counter can never wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       btn_s;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    state_t           state_q [2];
    state_t           state_d [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    logic [1:0]       pulse_q;
    logic [1:0]       pulse_d;
    logic [1:0]       level_q;
    logic [1:0]       level_d;

    assign btn_s = {btn_y, btn_x};

    // Two-flop synchroniser for both raw buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= btn_s;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel next-state, counter and output decode.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            pulse_d[ch] = 1'b0;
            case (state_q[ch])
                ST_IDLE: begin
                    if (sync2_q[ch]) begin
                        state_d[ch] = ST_WAIT_HIGH;
                        cnt_d[ch]   = CNT_ZERO;
                    end else begin
                        cnt_d[ch]   = CNT_ZERO;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!sync2_q[ch]) begin
                        // Bounce rejected; no pulse.
                        state_d[ch] = ST_IDLE;
                        cnt_d[ch]   = CNT_ZERO;
                    end else if (cnt_q[ch] == CNT_LAST) begin
                        state_d[ch] = ST_HIGH;
                        cnt_d[ch]   = CNT_ZERO;
                        pulse_d[ch] = 1'b1;
                    end else begin
                        cnt_d[ch]   = cnt_q[ch] + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!sync2_q[ch]) begin
                        state_d[ch] = ST_WAIT_LOW;
                        cnt_d[ch]   = CNT_ZERO;
                    end else begin
                        cnt_d[ch]   = CNT_ZERO;
                    end
                end
                ST_WAIT_LOW: begin
                    if (sync2_q[ch]) begin
                        // Release rejected; the press is still held.
                        state_d[ch] = ST_HIGH;
                        cnt_d[ch]   = CNT_ZERO;
                    end else if (cnt_q[ch] == CNT_LAST) begin
                        state_d[ch] = ST_IDLE;
                        cnt_d[ch]   = CNT_ZERO;
                    end else begin
                        cnt_d[ch]   = cnt_q[ch] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[ch] = ST_IDLE;
                    cnt_d[ch]   = CNT_ZERO;
                end
            endcase
            // The level register follows the state being entered, so it
            // rises on the same edge as the pulse.
            level_d[ch] = (state_d[ch] == ST_HIGH) || (state_d[ch] == ST_WAIT_LOW);
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= ST_IDLE;
                cnt_q[ch]   <= CNT_ZERO;
            end
            pulse_q <= 2'b00;
            level_q <= 2'b00;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    assign x       = pulse_q[0];
    assign y       = pulse_q[1];
    assign x_level = level_q[0];
    assign y_level = level_q[1];

endmodule

// File: tb/tb_dual_btn_pulse.sv
// ---------------------------------------------------------------------------
// tb_dual_btn_pulse
//
// Self-checking bench for dual_btn_pulse with DEBOUNCE_CYCLES=4. The bench
// numbers every rising clock edge. When a button input is changed just after
// edge N, edge N+1 is the first one that samples the new value. A press then
// produces its pulse, and an x_level change, on edge N+7 (edge 0 + 6).
// Expected event cycles are queued when stimulus is driven. Observed events
// are recorded by run() and then popped and compared by each test.
// ---------------------------------------------------------------------------
module tb_dual_btn_pulse;

    localparam int DB = 4;
    localparam int LAT = DB + 3;

    logic clk;
    logic rst;
    logic btn_x;
    logic btn_y;
    logic x;
    logic y;
    logic x_level;
    logic y_level;

    int checks;
    int failures;
    int cyc;
    logic prev_lx;

    int exp_x[$];
    int obs_x[$];
    int exp_y[$];
    int obs_y[$];
    int exp_lx[$];
    int obs_lx[$];

    dual_btn_pulse #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_x  (btn_x),
        .btn_y  (btn_y),
        .x      (x),
        .y      (y),
        .x_level(x_level),
        .y_level(y_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n edges. Sample 1 time unit after each edge and log
    // pulse cycles and x_level transitions.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (x === 1'b1) obs_x.push_back(cyc);
            if (y === 1'b1) obs_y.push_back(cyc);
            if (x_level !== prev_lx) begin
                obs_lx.push_back(cyc);
                prev_lx = x_level;
            end
        end
    endtask

    task automatic test_reset();
        int e, o;
        rst = 1'b1; btn_x = 1'b1; btn_y = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run(1);
            checks++;
            if ({x, y, x_level, y_level} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_outputs got=%b required=0000", {x, y, x_level, y_level});
            end
        end
        rst = 1'b0;
        exp_x.push_back(cyc + LAT); exp_y.push_back(cyc + LAT); exp_lx.push_back(cyc + LAT);
        run(20);
        btn_x = 1'b0; btn_y = 1'b0;
        exp_lx.push_back(cyc + LAT);
        run(12);
        checks++;
        if (y_level !== 1'b0) begin failures++; $display("FAIL reset_y_level_end got=%b required=0", y_level); end
        checks++;
        if (obs_x.size() != exp_x.size()) begin failures++; $display("FAIL reset_x_count got=%0d required=%0d", obs_x.size(), exp_x.size()); end
        while (exp_x.size() > 0 && obs_x.size() > 0) begin
            e = exp_x.pop_front(); o = obs_x.pop_front(); checks++;
            if (o != e) begin failures++; $display("FAIL reset_x_cycle got=%0d required=%0d", o, e); end
        end
        checks++;
        if (obs_y.size() != exp_y.size()) begin failures++; $display("FAIL reset_y_count got=%0d required=%0d", obs_y.size(), exp_y.size()); end
        while (exp_y.size() > 0 && obs_y.size() > 0) begin
            e = exp_y.pop_front(); o = obs_y.pop_front(); checks++;
            if (o != e) begin failures++; $display("FAIL reset_y_cycle got=%0d required=%0d", o, e); end
        end
        checks++;
        if (obs_lx.size() != exp_lx.size()) begin failures++; $display("FAIL reset_lx_count got=%0d required=%0d", obs_lx.size(), exp_lx.size()); end
        while (exp_lx.size() > 0 && obs_lx.size() > 0) begin
            e = exp_lx.pop_front(); o = obs_lx.pop_front(); checks++;
            if (o != e) begin failures++; $display("FAIL reset_lx_cycle got=%0d required=%0d", o, e); end
        end
        exp_x.delete(); obs_x.delete(); exp_y.delete(); obs_y.delete(); exp_lx.delete(); obs_lx.delete();
    endtask

    task automatic test_clean_press();
        int e, o;
        btn_x = 1'b1;
        exp_x.push_back(cyc + LAT); exp_lx.push_back(cyc + LAT);
        run(20);
        checks++;
        if (x_level !== 1'b1 || y_level !== 1'b0) begin
            failures++;
            $display("FAIL clean_levels got x_level=%b y_level=%b required 1 0", x_level, y_level);
        end
        btn_x = 1'b0;
        exp_lx.push_back(cyc + LAT);
        run(12);
        checks++;
        if (obs_x.size() != exp_x.size()) begin failures++; $display("FAIL clean_x_count got=%0d required=%0d", obs_x.size(), exp_x.size()); end
        while (exp_x.size() > 0 && obs_x.size() > 0) begin
            e = exp_x.pop_front(); o = obs_x.pop_front(); checks++;
            if (o != e) begin failures++; $display("FAIL clean_x_cycle got=%0d required=%0d", o, e); end
        end
        checks++;
        if (obs_y.size() != 0) begin failures++; $display("FAIL clean_y_count got=%0d required=0", obs_y.size()); end
        checks++;
        if (obs_lx.size() != exp_lx.size()) begin failures++; $display("FAIL clean_lx_count got=%0d required=%0d", obs_lx.size(), exp_lx.size()); end
        while (exp_lx.size() > 0 && obs_lx.size() > 0) begin
            e = exp_lx.pop_front(); o = obs_lx.pop_front(); checks++;
            if (o != e) begin failures++; $display("FAIL clean_lx_cycle got=%0d required=%0d", o, e); end
        end
        exp_x.delete(); obs_x.delete(); exp_y.delete(); obs_y.delete(); exp_lx.delete(); obs_lx.delete();
    endtask

    task automatic test_bounce();
        int e, o;
        btn_x = 1'b1; run(2);
        btn_x = 1'b0; run(2);
        btn_x = 1'b1; run(2);
        btn_x = 1'b0; run(2);
        btn_x = 1'b1;
        exp_x.push_back(cyc + LAT); exp_lx.push_back(cyc + LAT);
        run(20);
        btn_x = 1'b0;
        exp_lx.push_back(cyc + LAT);
        run(12);
        checks++;
        if (obs_x.size() != exp_x.size()) begin failures++; $display("FAIL bounce_x_count got=%0d required=%0d", obs_x.size(), exp_x.size()); end
        while (exp_x.size() > 0 && obs_x.size() > 0) begin
            e = exp_x.pop_front(); o = obs_x.pop_front(); checks++;
            if (o != e) begin failures++; $display("FAIL bounce_x_cycle got=%0d required=%0d", o, e); end
        end
        checks++;
        if (obs_lx.size() != exp_lx.size()) begin failures++; $display("FAIL bounce_lx_count got=%0d required=%0d", obs_lx.size(), exp_lx.size()); end
        while (exp_lx.size() > 0 && obs_lx.size() > 0) begin
            e = exp_lx.pop_front(); o = obs_lx.pop_front(); checks++;
            if (o != e) begin failures++; $display("FAIL bounce_lx_cycle got=%0d required=%0d", o, e); end
        end
        exp_x.delete(); obs_x.delete(); exp_y.delete(); obs_y.delete(); exp_lx.delete(); obs_lx.delete();
    endtask

    task automatic test_release_repress();
        int e, o;
        btn_x = 1'b1;
        exp_x.push_back(cyc + LAT); exp_lx.push_back(cyc + LAT);
        run(10);
        btn_x = 1'b0;
        exp_lx.push_back(cyc + LAT);
        run(10);
        btn_x = 1'b1;
        exp_x.push_back(cyc + LAT); exp_lx.push_back(cyc + LAT);
        run(20);
        btn_x = 1'b0;
        exp_lx.push_back(cyc + LAT);
        run(12);
        checks++;
        if (obs_x.size() != exp_x.size()) begin failures++; $display("FAIL repress_x_count got=%0d required=%0d", obs_x.size(), exp_x.size()); end
        while (exp_x.size() > 0 && obs_x.size() > 0) begin
            e = exp_x.pop_front(); o = obs_x.pop_front(); checks++;
            if (o != e) begin failures++; $display("FAIL repress_x_cycle got=%0d required=%0d", o, e); end
        end
        checks++;
        if (obs_lx.size() != exp_lx.size()) begin failures++; $display("FAIL repress_lx_count got=%0d required=%0d", obs_lx.size(), exp_lx.size()); end
        while (exp_lx.size() > 0 && obs_lx.size() > 0) begin
            e = exp_lx.pop_front(); o = obs_lx.pop_front(); checks++;
            if (o != e) begin failures++; $display("FAIL repress_lx_cycle got=%0d required=%0d", o, e); end
        end
        exp_x.delete(); obs_x.delete(); exp_y.delete(); obs_y.delete(); exp_lx.delete(); obs_lx.delete();
    endtask

    task automatic test_simultaneous();
        int e, o;
        btn_x = 1'b1; btn_y = 1'b1;
        exp_x.push_back(cyc + LAT); exp_y.push_back(cyc + LAT); exp_lx.push_back(cyc + LAT);
        run(20);
        checks++;
        if (x_level !== 1'b1 || y_level !== 1'b1) begin
            failures++;
            $display("FAIL simul_levels got x_level=%b y_level=%b required 1 1", x_level, y_level);
        end
        btn_x = 1'b0; btn_y = 1'b0;
        exp_lx.push_back(cyc + LAT);
        run(12);
        checks++;
        if (y_level !== 1'b0) begin failures++; $display("FAIL simul_y_level_end got=%b required=0", y_level); end
        checks++;
        if (obs_x.size() != exp_x.size()) begin failures++; $display("FAIL simul_x_count got=%0d required=%0d", obs_x.size(), exp_x.size()); end
        while (exp_x.size() > 0 && obs_x.size() > 0) begin
            e = exp_x.pop_front(); o = obs_x.pop_front(); checks++;
            if (o != e) begin failures++; $display("FAIL simul_x_cycle got=%0d required=%0d", o, e); end
        end
        checks++;
        if (obs_y.size() != exp_y.size()) begin failures++; $display("FAIL simul_y_count got=%0d required=%0d", obs_y.size(), exp_y.size()); end
        while (exp_y.size() > 0 && obs_y.size() > 0) begin
            e = exp_y.pop_front(); o = obs_y.pop_front(); checks++;
            if (o != e) begin failures++; $display("FAIL simul_y_cycle got=%0d required=%0d", o, e); end
        end
        checks++;
        if (obs_lx.size() != exp_lx.size()) begin failures++; $display("FAIL simul_lx_count got=%0d required=%0d", obs_lx.size(), exp_lx.size()); end
        while (exp_lx.size() > 0 && obs_lx.size() > 0) begin
            e = exp_lx.pop_front(); o = obs_lx.pop_front(); checks++;
            if (o != e) begin failures++; $display("FAIL simul_lx_cycle got=%0d required=%0d", o, e); end
        end
        exp_x.delete(); obs_x.delete(); exp_y.delete(); obs_y.delete(); exp_lx.delete(); obs_lx.delete();
    endtask

    task automatic test_mid_reset();
        int e, o;
        btn_x = 1'b1;
        run(4);
        // The next edge is edge 4 of the press, while the FSM is in WAIT_HIGH.
        rst = 1'b1;
        run(1);
        checks++;
        if ({x, y, x_level, y_level} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_outputs got=%b required=0000", {x, y, x_level, y_level});
        end
        rst = 1'b0;
        exp_x.push_back(cyc + LAT); exp_lx.push_back(cyc + LAT);
        run(20);
        btn_x = 1'b0;
        exp_lx.push_back(cyc + LAT);
        run(12);
        checks++;
        if (obs_x.size() != exp_x.size()) begin failures++; $display("FAIL midrst_x_count got=%0d required=%0d", obs_x.size(), exp_x.size()); end
        while (exp_x.size() > 0 && obs_x.size() > 0) begin
            e = exp_x.pop_front(); o = obs_x.pop_front(); checks++;
            if (o != e) begin failures++; $display("FAIL midrst_x_cycle got=%0d required=%0d", o, e); end
        end
        checks++;
        if (obs_lx.size() != exp_lx.size()) begin failures++; $display("FAIL midrst_lx_count got=%0d required=%0d", obs_lx.size(), exp_lx.size()); end
        while (exp_lx.size() > 0 && obs_lx.size() > 0) begin
            e = exp_lx.pop_front(); o = obs_lx.pop_front(); checks++;
            if (o != e) begin failures++; $display("FAIL midrst_lx_cycle got=%0d required=%0d", o, e); end
        end
        exp_x.delete(); obs_x.delete(); exp_y.delete(); obs_y.delete(); exp_lx.delete(); obs_lx.delete();
    endtask

    // Test sequence.
    initial begin
        checks = 0; failures = 0; cyc = 0; prev_lx = 1'b0;
        rst = 1'b1; btn_x = 1'b0; btn_y = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_repress();
        test_simultaneous();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
